// File: rtl/sim_phase_sequencer_pkg.sv
// Shared types and default parameter values for the phase sequencer.
//   seq_state_e  : sequencer FSM states
//   fail_code_e  : reason reported on fail_code while in the fail state
package sim_seq_pkg;

  localparam int unsigned DefNumPhases = 4;
  localparam int unsigned DefLenW      = 8;
  localparam int unsigned DefCycW      = 16;
  localparam int unsigned DefTimeout   = 1000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2,
    StFail = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    FailNone    = 2'd0,
    FailChkErr  = 2'd1,
    FailTimeout = 2'd2
  } fail_code_e;

endpackage

// File: rtl/sim_phase_sequencer_if.sv
// Control/status bundle between a test controller (master) and the sequencer (slave).
//   cfg_we/cfg_idx/cfg_len : phase-length table write
//   start/abort/err        : run control and checker error
//   phase_id .. fail_code  : sequencer status
interface sim_phase_sequencer_if import sim_seq_pkg::*; #(
  parameter int unsigned NUM_PHASES = DefNumPhases,
  parameter int unsigned LEN_W      = DefLenW,
  parameter int unsigned CYC_W      = DefCycW
);
  localparam int unsigned IDX_W = $clog2(NUM_PHASES);

  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [LEN_W-1:0] cfg_len;
  logic             start;
  logic             abort;
  logic             err;
  logic [IDX_W-1:0] phase_id;
  logic             phase_active;
  logic             phase_first;
  logic [CYC_W-1:0] cyc;
  logic             finish;
  logic             pass;
  logic [1:0]       fail_code;

  modport master (
    output cfg_we, cfg_idx, cfg_len, start, abort, err,
    input  phase_id, phase_active, phase_first, cyc, finish, pass, fail_code
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_len, start, abort, err,
    output phase_id, phase_active, phase_first, cyc, finish, pass, fail_code
  );

endinterface

// File: rtl/sim_cyc_counter.sv
// Saturating up-counter with synchronous clear (priority) and enable.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : clear to zero
//   en_i     : count up, holding at all-ones
//   cnt_o    : current count
module sim_cyc_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sim_phase_sequencer.sv
// Steps a simulation through a table of test phases of programmable length, tracking
// checker errors per phase and a global watchdog.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of sim_phase_sequencer_if (table writes, start/abort/err in;
//              phase_id, phase_active, phase_first, cyc, finish, pass, fail_code out)
module sim_phase_sequencer import sim_seq_pkg::*; #(
  parameter int unsigned NUM_PHASES = DefNumPhases,
  parameter int unsigned LEN_W      = DefLenW,
  parameter int unsigned CYC_W      = DefCycW,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input logic                 clk,
  input logic                 rst,
  sim_phase_sequencer_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_PHASES);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] phase_q, phase_d;
  logic             flag_q, flag_d;
  logic             finish_q, finish_d;
  fail_code_e       code_q, code_d;

  logic [LEN_W-1:0] len_q [NUM_PHASES];
  logic [LEN_W-1:0] cur_len;
  logic [LEN_W-1:0] pcnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic             pcnt_clr, pcnt_en, cyc_clr, cyc_en;

  logic             first_found, next_found;
  logic [IDX_W-1:0] first_idx, next_idx;
  logic             last_cyc;

  // Phase-length table; writable only outside a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PHASES; i++) begin
        len_q[i] <= LEN_W'(1);
      end
    end else if (bus.cfg_we && (state_q != StRun) && (32'(bus.cfg_idx) < NUM_PHASES)) begin
      len_q[bus.cfg_idx] <= bus.cfg_len;
    end
  end

  // First nonzero phase overall, and first nonzero phase after the current one.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (len_q[i] != '0) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = IDX_W'(i);
        end
        if (!next_found && (i > 32'(phase_q))) begin
          next_found = 1'b1;
          next_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign cur_len  = len_q[phase_q];
  assign last_cyc = (pcnt == (cur_len - LEN_W'(1)));

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    flag_d   = flag_q;
    code_d   = code_q;
    finish_d = 1'b0;
    pcnt_clr = 1'b0;
    pcnt_en  = 1'b0;
    cyc_clr  = 1'b0;
    cyc_en   = 1'b0;
    unique case (state_q)
      StRun: begin
        cyc_en  = 1'b1;
        pcnt_en = 1'b1;
        // Sticky error restarts on each phase's first cycle, but err on that cycle counts.
        flag_d  = ((pcnt == '0) ? 1'b0 : flag_q) | bus.err;
        if (bus.abort) begin
          state_d  = StIdle;
          code_d   = FailNone;
          flag_d   = 1'b0;
          pcnt_clr = 1'b1;
        end else if (cyc_cnt == CYC_W'(TIMEOUT - 1)) begin
          state_d  = StFail;
          code_d   = FailTimeout;
          finish_d = 1'b1;
        end else if (last_cyc) begin
          pcnt_clr = 1'b1;
          if (flag_d) begin
            state_d  = StFail;
            code_d   = FailChkErr;
            finish_d = 1'b1;
          end else if (next_found) begin
            phase_d = next_idx;
          end else begin
            state_d  = StDone;
            finish_d = 1'b1;
          end
        end
      end
      StIdle, StDone, StFail: begin
        if (bus.start) begin
          cyc_clr  = 1'b1;
          pcnt_clr = 1'b1;
          code_d   = FailNone;
          flag_d   = 1'b0;
          if (first_found) begin
            state_d = StRun;
            phase_d = first_idx;
          end else begin
            // Nothing to run: report success immediately.
            state_d  = StDone;
            finish_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      flag_q   <= 1'b0;
      finish_q <= 1'b0;
      code_q   <= FailNone;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      flag_q   <= flag_d;
      finish_q <= finish_d;
      code_q   <= code_d;
    end
  end

  sim_cyc_counter #(
    .W (LEN_W)
  ) u_phase_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (pcnt_clr),
    .en_i  (pcnt_en),
    .cnt_o (pcnt)
  );

  sim_cyc_counter #(
    .W (CYC_W)
  ) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cyc_clr),
    .en_i  (cyc_en),
    .cnt_o (cyc_cnt)
  );

  assign bus.phase_id     = phase_q;
  assign bus.phase_active = (state_q == StRun);
  assign bus.phase_first  = (state_q == StRun) && (pcnt == '0);
  assign bus.cyc          = cyc_cnt;
  assign bus.finish       = finish_q;
  assign bus.pass         = (state_q == StDone);
  assign bus.fail_code    = code_q;

endmodule

// File: tb/tb_sim_phase_sequencer.sv
module tb_sim_phase_sequencer;

  localparam int unsigned NP = 5;
  localparam int unsigned LW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 40;
  localparam int unsigned IW = $clog2(NP);

  typedef struct packed {
    logic          fin;
    logic [IW-1:0] pid;
    logic [CW-1:0] cyc;
    logic          pass;
    logic [1:0]    code;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sim_phase_sequencer_if #(.NUM_PHASES(NP), .LEN_W(LW), .CYC_W(CW)) bus ();

  sim_phase_sequencer #(
    .NUM_PHASES (NP),
    .LEN_W      (LW),
    .CYC_W      (CW),
    .TIMEOUT    (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  tbl[NP];
  int  model_pid;
  bit  errv[64];
  ev_t mon_act, mon_exp;

  function automatic ev_t mk_ev(input bit fin, input int pid, input int cyc, input bit pass,
                                input int code);
    ev_t e;
    e.fin  = fin;
    e.pid  = IW'(pid);
    e.cyc  = CW'(cyc);
    e.pass = pass;
    e.code = 2'(code);
    return e;
  endfunction

  // Monitor: every phase_first or finish pulse must match the next expected event.
  always @(negedge clk) begin
    if (!rst && (bus.phase_first || bus.finish)) begin
      mon_act.fin  = bus.finish;
      mon_act.pid  = bus.phase_id;
      mon_act.cyc  = bus.cyc;
      mon_act.pass = bus.pass;
      mon_act.code = bus.fail_code;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got fin=%0d pid=%0d cyc=%0d pass=%0d code=%0d",
                 mon_act.fin, mon_act.pid, mon_act.cyc, mon_act.pass, mon_act.code);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL event got fin=%0d pid=%0d cyc=%0d pass=%0d code=%0d want fin=%0d pid=%0d cyc=%0d pass=%0d code=%0d",
                   mon_act.fin, mon_act.pid, mon_act.cyc, mon_act.pass, mon_act.code,
                   mon_exp.fin, mon_exp.pid, mon_exp.cyc, mon_exp.pass, mon_exp.code);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_phase_id"}, 32'(bus.phase_id), 0);
    chk({tag, "_active"}, 32'(bus.phase_active), 0);
    chk({tag, "_first"}, 32'(bus.phase_first), 0);
    chk({tag, "_cyc"}, 32'(bus.cyc), 0);
    chk({tag, "_finish"}, 32'(bus.finish), 0);
    chk({tag, "_pass"}, 32'(bus.pass), 0);
    chk({tag, "_code"}, 32'(bus.fail_code), 0);
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) tbl[p] = 1;
    model_pid = 0;
  endtask

  task automatic cfg_write(input int idx, input int len);
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = IW'(idx);
    bus.cfg_len = LW'(len);
    step();
    bus.cfg_we = 1'b0;
    if (idx < NP) tbl[idx] = len;
  endtask

  task automatic set_table(input int a, input int b, input int c, input int d, input int e);
    cfg_write(0, a);
    cfg_write(1, b);
    cfg_write(2, c);
    cfg_write(3, d);
    cfg_write(4, e);
  endtask

  task automatic clear_errv();
    for (int k = 0; k < 64; k++) errv[k] = 1'b0;
  endtask

  // Reference: walk the phase table in RUN-cycle time, pushing expected pulses.
  // n = RUN cycles spent before leaving RUN.
  task automatic model_run(input int ab, output int n, output bit aborted,
                           output int fpass, output int fcode);
    int  t;
    int  e;
    bit  stop;
    bit  bad;
    t = 0; stop = 0; n = 0; aborted = 0; fpass = 0; fcode = 0;
    for (int p = 0; p < NP; p++) begin
      if (!stop && tbl[p] != 0) begin
        exp_q.push_back(mk_ev(0, p, t, 0, 0));
        model_pid = p;
        e = t + tbl[p] - 1;
        for (int k = t; k <= e; k++) begin
          if (!stop) begin
            if (k == ab) begin
              stop = 1; aborted = 1; n = k + 1;
            end else if (k == TO - 1) begin
              stop = 1; n = k + 1; fcode = 2;
              exp_q.push_back(mk_ev(1, p, k + 1, 0, 2));
            end
          end
        end
        if (!stop) begin
          bad = 0;
          for (int k = t; k <= e; k++) bad |= errv[k];
          if (bad) begin
            stop = 1; n = e + 1; fcode = 1;
            exp_q.push_back(mk_ev(1, p, e + 1, 0, 1));
          end else begin
            t = e + 1;
          end
        end
      end
    end
    if (!stop) begin
      n = t; fpass = 1;
      exp_q.push_back(mk_ev(1, model_pid, t, 1, 0));
    end
  endtask

  task automatic run_seq(input int ab, input int rst_at, input string tag);
    int n;
    bit aborted;
    int fpass, fcode;
    model_run(ab, n, aborted, fpass, fcode);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({tag, "_start_active"}, 32'(bus.phase_active), 32'(n > 0));
    chk({tag, "_start_pass"}, 32'(bus.pass), 32'(n == 0));
    chk({tag, "_start_cyc"}, 32'(bus.cyc), 0);
    for (int k = 0; k < n; k++) begin
      if (k == rst_at) begin
        bus.err = 1'b0; bus.abort = 1'b0; bus.cfg_we = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_outputs({tag, "_async"});
        exp_q.delete();
        step();
        rst = 1'b0;
        model_reset();
        return;
      end
      bus.err     = errv[k];
      bus.abort   = (k == ab);
      bus.cfg_we  = 1'($urandom_range(0, 1));
      bus.cfg_idx = IW'($urandom);
      bus.cfg_len = LW'($urandom);
      step();
    end
    bus.err = 1'b0; bus.abort = 1'b0; bus.cfg_we = 1'b0;
    chk({tag, "_end_active"}, 32'(bus.phase_active), 0);
    chk({tag, "_end_finish"}, 32'(bus.finish), 32'(!aborted));
    chk({tag, "_end_pass"}, 32'(bus.pass), 32'(fpass));
    chk({tag, "_end_code"}, 32'(bus.fail_code), 32'(fcode));
    step();
    chk({tag, "_finish_once"}, 32'(bus.finish), 0);
    chk({tag, "_pass_held"}, 32'(bus.pass), 32'(fpass));
    chk({tag, "_events_drained"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int ab;
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_len = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.err = 1'b0;
    model_reset();
    clear_errv();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs("por");

    run_seq(-1, -1, "dflt_ones");

    set_table(3, 2, 4, 1, 0);
    run_seq(-1, -1, "basic");
    run_seq(-1, -1, "restart");

    errv[4] = 1'b1;
    run_seq(-1, -1, "chkerr");
    clear_errv();

    set_table(0, 5, 0, 2, 0);
    run_seq(-1, -1, "skip");

    set_table(30, 30, 30, 30, 30);
    errv[TO-1] = 1'b1;
    run_seq(-1, -1, "timeout");
    clear_errv();

    set_table(3, 2, 4, 1, 0);
    run_seq(6, -1, "abort");
    run_seq(-1, -1, "after_abort");

    run_seq(-1, 2, "midrst");
    run_seq(-1, -1, "post_rst");

    set_table(0, 0, 0, 0, 0);
    run_seq(-1, -1, "allzero");
    run_seq(-1, -1, "allzero_again");

    cfg_write(6, 9);
    cfg_write(2, 2);
    run_seq(-1, -1, "bad_idx");

    repeat (40) begin
      repeat ($urandom_range(0, 3)) begin
        cfg_write(int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12)));
      end
      for (int k = 0; k < 64; k++) errv[k] = ($urandom_range(0, 29) == 0);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 30)) : -1;
      run_seq(ab, -1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
